// File: rtl/ps2_mouse_interface.sv
`timescale 1ns/1ps
// Host-side PS/2 mouse controller: sends Enable Data Reporting (0xF4) after
// reset, checks the device line ACK, waits for the 0xFA acknowledge byte and
// then decodes standard 3-byte mouse packets into buttons and 9-bit X/Y steps.
// Ports: clk/reset (sync, active-high); ps2_clk/ps2_data open-collector pins
// (driven only 0 or Z); left_button/right_button/x_increment/y_increment hold
// the last packet; data_ready/read handshake; error_no_ack sticky flag.
module ps2_mouse_interface #(
  parameter int WATCHDOG_TIMER_VALUE_PP = 10800,
  parameter int WATCHDOG_TIMER_BITS_PP  = 14,
  parameter int DEBOUNCE_TIMER_VALUE_PP = 100,
  parameter int DEBOUNCE_TIMER_BITS_PP  = 7
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        ps2_clk,
  inout  wire        ps2_data,
  output logic       left_button,
  output logic       right_button,
  output logic [8:0] x_increment,
  output logic [8:0] y_increment,
  output logic       data_ready,
  input  logic       read,
  output logic       error_no_ack
);

  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] ACK_BYTE   = 8'hFA;
  localparam logic [WATCHDOG_TIMER_BITS_PP-1:0] WD_RELOAD =
    WATCHDOG_TIMER_BITS_PP'(WATCHDOG_TIMER_VALUE_PP);
  localparam logic [WATCHDOG_TIMER_BITS_PP-1:0] WD_ONE = WATCHDOG_TIMER_BITS_PP'(1);
  localparam logic [DEBOUNCE_TIMER_BITS_PP-1:0] DB_RELOAD =
    DEBOUNCE_TIMER_BITS_PP'(DEBOUNCE_TIMER_VALUE_PP);
  localparam logic [DEBOUNCE_TIMER_BITS_PP-1:0] DB_ONE = DEBOUNCE_TIMER_BITS_PP'(1);

  typedef enum logic [2:0] {
    S_INHIBIT,
    S_RTS,
    S_TX_SHIFT,
    S_TX_ACK,
    S_RX_WAIT_FA,
    S_RX_PACKET,
    S_ERROR
  } state_t;

  state_t state, next_state;

  // Pin synchronizers; idle level of both lines is high.
  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;

  logic [DEBOUNCE_TIMER_BITS_PP-1:0] deb_cnt;
  logic [WATCHDOG_TIMER_BITS_PP-1:0] wd_cnt;
  logic fall_edge;
  logic wd_load;
  logic wd_expired;

  logic       clk_drive_low;
  logic       data_drive_low;
  logic [9:0] tx_shift;
  logic [3:0] tx_cnt;

  logic [9:0] rx_shift;
  logic [3:0] rx_cnt;
  logic [1:0] byte_idx;
  logic       st_lb, st_rb, st_xs, st_ys;
  logic [7:0] x_byte;

  logic       rx_active, rx_edge, rx_done, rx_frame_ok, rx_resync, pkt_done;
  logic [7:0] rx_byte;

  assign ps2_clk  = clk_drive_low  ? 1'b0 : 1'bz;
  assign ps2_data = data_drive_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  // Any level change restarts the stability count. The edge fires once, when
  // a low level has been stable for the full debounce time.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt <= '0;
    end else if (clk_s2 != clk_prev) begin
      deb_cnt <= DB_RELOAD;
    end else if (deb_cnt != '0) begin
      deb_cnt <= deb_cnt - DB_ONE;
    end
  end

  assign fall_edge = !clk_s2 && (clk_s2 == clk_prev) && (deb_cnt == DB_ONE);

  // One watchdog serves inhibit time, ACK timeout and receive resync. During
  // INHIBIT our own pull-down produces an edge, which must not extend it.
  assign wd_load    = fall_edge && (state != S_INHIBIT);
  assign wd_expired = (wd_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= WD_RELOAD;
    end else if (wd_load) begin
      wd_cnt <= WD_RELOAD;
    end else if (!wd_expired) begin
      wd_cnt <= wd_cnt - WD_ONE;
    end
  end

  // Receive framing: after 10 shifts rx_shift holds {parity, data, start} and
  // the current data sample is the stop bit.
  assign rx_active   = (state == S_RX_WAIT_FA) || (state == S_RX_PACKET);
  assign rx_edge     = rx_active && fall_edge;
  assign rx_done     = rx_edge && (rx_cnt == 4'd10);
  assign rx_byte     = rx_shift[8:1];
  assign rx_frame_ok = !rx_shift[0] && data_s2 && (^rx_shift[9:1]);
  assign rx_resync   = rx_active && !fall_edge && wd_expired &&
                       ((rx_cnt != 4'd0) || (byte_idx != 2'd0));
  assign pkt_done    = (state == S_RX_PACKET) && rx_done && rx_frame_ok &&
                       (byte_idx == 2'd2);

  always_comb begin
    next_state = state;
    case (state)
      S_INHIBIT:    if (wd_expired) next_state = S_RTS;
      S_RTS:        next_state = S_TX_SHIFT;
      S_TX_SHIFT:   if (fall_edge && (tx_cnt == 4'd9)) next_state = S_TX_ACK;
      S_TX_ACK: begin
        if (fall_edge) begin
          next_state = data_s2 ? S_ERROR : S_RX_WAIT_FA;
        end else if (wd_expired) begin
          next_state = S_ERROR;
        end
      end
      S_RX_WAIT_FA: if (rx_done && rx_frame_ok && (rx_byte == ACK_BYTE)) next_state = S_RX_PACKET;
      S_RX_PACKET:  next_state = S_RX_PACKET;
      S_ERROR:      next_state = S_ERROR;
      default:      next_state = S_INHIBIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_INHIBIT;
      clk_drive_low  <= 1'b0;
      data_drive_low <= 1'b0;
      tx_shift       <= '0;
      tx_cnt         <= '0;
      rx_shift       <= '0;
      rx_cnt         <= '0;
      byte_idx       <= '0;
      st_lb          <= 1'b0;
      st_rb          <= 1'b0;
      st_xs          <= 1'b0;
      st_ys          <= 1'b0;
      x_byte         <= '0;
      left_button    <= 1'b0;
      right_button   <= 1'b0;
      x_increment    <= '0;
      y_increment    <= '0;
      data_ready     <= 1'b0;
      error_no_ack   <= 1'b0;
    end else begin
      state         <= next_state;
      clk_drive_low <= (next_state == S_INHIBIT);
      if (next_state == S_ERROR) error_no_ack <= 1'b1;

      // Transmit: the start bit goes out with RTS; each accepted edge then
      // presents the next of data[7:0], odd parity, stop (released).
      if ((state == S_INHIBIT) && (next_state == S_RTS)) begin
        tx_shift       <= {1'b1, ~^CMD_ENABLE, CMD_ENABLE};
        tx_cnt         <= 4'd0;
        data_drive_low <= 1'b1;
      end else if (state == S_TX_SHIFT) begin
        if (fall_edge) begin
          data_drive_low <= ~tx_shift[0];
          tx_shift       <= {1'b1, tx_shift[9:1]};
          tx_cnt         <= tx_cnt + 4'd1;
        end
      end else if (state != S_RTS) begin
        data_drive_low <= 1'b0;
      end

      if (rx_edge) begin
        rx_shift <= {data_s2, rx_shift[9:1]};
        rx_cnt   <= rx_done ? 4'd0 : rx_cnt + 4'd1;
      end else if (rx_resync) begin
        rx_cnt <= 4'd0;
      end

      if (state == S_RX_PACKET) begin
        if (rx_done) begin
          if (!rx_frame_ok) begin
            byte_idx <= 2'd0;
          end else begin
            case (byte_idx)
              2'd0: begin
                // Bit3 is always set in a real status byte; use it to resync.
                if (rx_byte[3]) begin
                  st_lb    <= rx_byte[0];
                  st_rb    <= rx_byte[1];
                  st_xs    <= rx_byte[4];
                  st_ys    <= rx_byte[5];
                  byte_idx <= 2'd1;
                end
              end
              2'd1: begin
                x_byte   <= rx_byte;
                byte_idx <= 2'd2;
              end
              default: begin
                left_button  <= st_lb;
                right_button <= st_rb;
                x_increment  <= {st_xs, x_byte};
                y_increment  <= {st_ys, rx_byte};
                byte_idx     <= 2'd0;
              end
            endcase
          end
        end else if (rx_resync) begin
          byte_idx <= 2'd0;
        end
      end

      // A completing packet wins over a simultaneous read.
      if (pkt_done) begin
        data_ready <= 1'b1;
      end else if (read) begin
        data_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_interface.sv
`timescale 1ns/1ps
module tb_ps2_mouse_interface;

  localparam int WD    = 300;
  localparam int DB    = 5;
  localparam int HALF  = 20;
  localparam int SETUP = 5;
  localparam int GAP   = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic read = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  wire ps2_clk_w;
  wire ps2_data_w;
  pullup (ps2_clk_w);
  pullup (ps2_data_w);
  assign ps2_clk_w  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data_w = dev_data_low ? 1'b0 : 1'bz;

  logic       left_button, right_button, data_ready, error_no_ack;
  logic [8:0] x_increment, y_increment;

  ps2_mouse_interface #(
    .WATCHDOG_TIMER_VALUE_PP(WD),
    .WATCHDOG_TIMER_BITS_PP (14),
    .DEBOUNCE_TIMER_VALUE_PP(DB),
    .DEBOUNCE_TIMER_BITS_PP (7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk_w),
    .ps2_data    (ps2_data_w),
    .left_button (left_button),
    .right_button(right_button),
    .x_increment (x_increment),
    .y_increment (y_increment),
    .data_ready  (data_ready),
    .read        (read),
    .error_no_ack(error_no_ack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int dr_rises = 0;
  int exp_rises = 0;
  logic dr_prev = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    dr_prev <= data_ready;
    if (data_ready && !dr_prev) dr_rises <= dr_rises + 1;
  end

  initial begin
    #950000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    read = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
  endtask

  // Device side of a host-to-device transfer. bits[9:0] = data0..7, parity, stop.
  task automatic host_frame(input bit give_ack, output logic [9:0] bits,
                            output int low_cycles, output int fall10, output bit ok);
    int n;
    ok = 1'b1;
    bits = '0;
    low_cycles = 0;
    fall10 = 0;
    n = 0;
    while (ps2_clk_w !== 1'b0 && n < 4 * WD) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4 * WD) begin
      ok = 1'b0;
      return;
    end
    while (ps2_clk_w === 1'b0 && low_cycles < 4 * WD) begin
      @(negedge clk);
      low_cycles++;
    end
    if (low_cycles >= 4 * WD) begin
      ok = 1'b0;
      return;
    end
    check("rts_data_low", {31'd0, ps2_data_w}, 32'd0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      fall10 = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      @(negedge clk);
      bits[i] = ps2_data_w;
      repeat (HALF - 1) @(negedge clk);
    end
    if (give_ack) begin
      dev_data_low = 1'b1;
      repeat (SETUP) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_data_low = 1'b0;
      repeat (GAP) @(negedge clk);
    end
  endtask

  // Device-to-host frame; nbits < 11 sends a truncated frame.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_data_low = ~f[i];
      repeat (SETUP) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_data_low = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  // Reference decode straight from the packet format, via signed arithmetic.
  function automatic logic [8:0] to9(input logic sign, input logic [7:0] mag);
    int v;
    v = sign ? int'(mag) - 256 : int'(mag);
    return v[8:0];
  endfunction

  task automatic send_packet(input logic [7:0] s, input logic [7:0] x,
                             input logic [7:0] y, input bit read_tied);
    int n;
    int rises_before;
    rises_before = dr_rises;
    read = read_tied;
    send_frame(s, 1'b0, 11);
    send_frame(x, 1'b0, 11);
    send_frame(y, 1'b0, 11);
    exp_rises++;
    check("pkt_one_pulse", dr_rises - rises_before, 1);
    if (read_tied) begin
      check("pulse_cleared", {31'd0, data_ready}, 32'd0);
      read = 1'b0;
    end else begin
      n = 0;
      while (!data_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("data_ready_set", {31'd0, data_ready}, 32'd1);
      repeat (3) @(negedge clk);
      check("data_ready_held", {31'd0, data_ready}, 32'd1);
      read = 1'b1;
      @(negedge clk);
      read = 1'b0;
      check("data_ready_cleared", {31'd0, data_ready}, 32'd0);
    end
    check("left_button", {31'd0, left_button}, {31'd0, s[0]});
    check("right_button", {31'd0, right_button}, {31'd0, s[1]});
    check("x_increment", {23'd0, x_increment}, {23'd0, to9(s[4], x)});
    check("y_increment", {23'd0, y_increment}, {23'd0, to9(s[5], y)});
  endtask

  task automatic expect_idle(input string tag, input int rises_before);
    check(tag, dr_rises - rises_before, 0);
  endtask

  initial begin
    logic [9:0] fbits;
    int low_cycles, fall10, n, rb;
    bit ok;
    logic [7:0] s, x, y;

    // Reset values and released lines.
    repeat (3) @(negedge clk);
    check("rst_data_ready", {31'd0, data_ready}, 32'd0);
    check("rst_error", {31'd0, error_no_ack}, 32'd0);
    check("rst_buttons", {30'd0, left_button, right_button}, 32'd0);
    check("rst_x", {23'd0, x_increment}, 32'd0);
    check("rst_y", {23'd0, y_increment}, 32'd0);
    check("rst_clk_released", {31'd0, ps2_clk_w}, 32'd1);
    check("rst_data_released", {31'd0, ps2_data_w}, 32'd1);

    // Device never clocks out the ACK bit.
    do_reset();
    host_frame(1'b0, fbits, low_cycles, fall10, ok);
    check("noack_request_seen", {31'd0, ok}, 32'd1);
    check("noack_error_early", {31'd0, error_no_ack}, 32'd0);
    n = 0;
    while (!error_no_ack && n < 4 * WD) begin
      @(negedge clk);
      n++;
    end
    check("noack_error_set", {31'd0, error_no_ack}, 32'd1);
    check("noack_not_too_early", {31'd0, (cyc - fall10) >= WD}, 32'd1);
    check("noack_not_too_late", {31'd0, (cyc - fall10) <= WD + DB + 20}, 32'd1);
    repeat (100) @(negedge clk);
    check("noack_error_sticky", {31'd0, error_no_ack}, 32'd1);
    check("noack_clk_released", {31'd0, ps2_clk_w}, 32'd1);
    check("noack_data_released", {31'd0, ps2_data_w}, 32'd1);

    // Normal start-up with ACK.
    do_reset();
    check("rst2_error_clear", {31'd0, error_no_ack}, 32'd0);
    host_frame(1'b1, fbits, low_cycles, fall10, ok);
    check("tx_request_seen", {31'd0, ok}, 32'd1);
    check("inhibit_low_time", {31'd0, low_cycles >= WD}, 32'd1);
    check("tx_data_byte", {24'd0, fbits[7:0]}, 32'hF4);
    check("tx_odd_parity", {31'd0, ^fbits[8:0]}, 32'd1);
    check("tx_stop", {31'd0, fbits[9]}, 32'd1);
    check("ack_no_error", {31'd0, error_no_ack}, 32'd0);

    // Packet-looking bytes before the 0xFA acknowledge are ignored.
    rb = dr_rises;
    send_frame(8'h28, 1'b0, 11);
    send_frame(8'h05, 1'b0, 11);
    send_frame(8'hFF, 1'b0, 11);
    expect_idle("pre_fa_ignored", rb);
    send_frame(8'hFA, 1'b0, 11);

    send_packet(8'h28, 8'h05, 8'hFF, 1'b0);
    send_packet(8'h19, 8'hF6, 8'h14, 1'b0);
    send_packet(8'h0A, 8'h00, 8'h00, 1'b0);
    send_packet(8'h28, 8'h7F, 8'h80, 1'b0);

    // Wrong parity on the X byte drops the packet.
    rb = dr_rises;
    send_frame(8'h09, 1'b0, 11);
    send_frame(8'h33, 1'b1, 11);
    send_frame(8'h44, 1'b0, 11);
    expect_idle("bad_parity_dropped", rb);
    send_packet(8'h1A, 8'hE0, 8'h10, 1'b0);

    // Status byte without bit3 is discarded.
    rb = dr_rises;
    send_frame(8'h03, 1'b0, 11);
    expect_idle("bit3_clear_dropped", rb);
    send_packet(8'h09, 8'h01, 8'h02, 1'b0);

    // Packet abandoned after one byte, then a long gap.
    rb = dr_rises;
    send_frame(8'h08, 1'b0, 11);
    repeat (WD + 200) @(negedge clk);
    expect_idle("abort_gap_idle", rb);
    send_packet(8'h38, 8'h80, 8'h7F, 1'b0);

    // Truncated frame, then a long gap.
    rb = dr_rises;
    send_frame(8'h55, 1'b0, 5);
    repeat (WD + 200) @(negedge clk);
    expect_idle("partial_frame_idle", rb);
    send_packet(8'h0B, 8'h10, 8'h20, 1'b0);

    // read tied high gives a single-cycle pulse.
    send_packet(8'h2A, 8'h03, 8'hFD, 1'b1);

    for (int i = 0; i < 8; i++) begin
      s = 8'($urandom) | 8'h08;
      x = 8'($urandom);
      y = 8'($urandom);
      send_packet(s, x, y, i[0]);
    end

    // Reset mid-frame restarts the whole init sequence.
    send_frame(8'h08, 1'b0, 6);
    do_reset();
    check("midrst_x_cleared", {23'd0, x_increment}, 32'd0);
    check("midrst_ready_clear", {31'd0, data_ready}, 32'd0);
    host_frame(1'b1, fbits, low_cycles, fall10, ok);
    check("re_request_seen", {31'd0, ok}, 32'd1);
    check("re_tx_data_byte", {24'd0, fbits[7:0]}, 32'hF4);
    send_frame(8'hFA, 1'b0, 11);
    send_packet(8'h19, 8'hF6, 8'h14, 1'b0);

    repeat (5) @(negedge clk);
    check("total_ready_pulses", dr_rises, exp_rises);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
